tx_pkt_fifo_ctrl: RTL and testbench

TX_PKT_FIFO_CTRL -- requirements
Module: tx_pkt_fifo_ctrl

---
 rtl/tx_fifo_pkg.sv | 17 +
 rtl/pkt_len_fifo.sv | 53 +++++
 rtl/tx_pkt_fifo_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tx_pkt_fifo_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
// Shared state encodings and default sizes for the tx packet FIFO controller.
package tx_fifo_pkg;
    localparam int DWIDTH_DEF    = 32;
    localparam int AWIDTH_DEF    = 10;
    localparam int LEN_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_PKT  = 1'b1
    } rd_state_e;
endpackage

// File: rtl/pkt_len_fifo.sv
// Registered FIFO of committed packet lengths; push is ignored when full, pop when empty.
module pkt_len_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    count;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rp];

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= nxt(wp);
            if (pop_ok)  rp <= nxt(rp);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tx_pkt_fifo_ctrl.sv
// Store-and-forward tx packet FIFO: packets are released only after eop commits them.
// Define TX_FIFO_STATS_EN to enable the pkt_cnt/drop_cnt counters (tied to 0 otherwise).
module tx_pkt_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int LEN_DEPTH = LEN_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    input  logic                           s_sop,
    input  logic                           s_eop,
    input  logic [DWIDTH-1:0]              s_data,
    output logic                           s_ready,
    output logic                           m_valid,
    output logic                           m_sop,
    output logic                           m_eop,
    output logic [DWIDTH-1:0]              m_data,
    input  logic                           m_ready,
    output logic [AWIDTH-1:0]              mem_waddr,
    output logic [DWIDTH-1:0]              mem_wdata,
    output logic                           mem_write,
    output logic [AWIDTH-1:0]              mem_raddr,
    input  logic [DWIDTH-1:0]              mem_rdata,
    output logic [$clog2(LEN_DEPTH+1)-1:0] pkt_cnt,
    output logic [15:0]                    drop_cnt,
    output wr_state_e                      dbg_wr_state,
    output rd_state_e                      dbg_rd_state
);
    localparam int PW = AWIDTH + 1;
    localparam int CW = $clog2(LEN_DEPTH + 1);
    localparam logic [PW-1:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    wr_state_e     wr_state, wr_next;
    rd_state_e     rd_state;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, remaining;
    logic [PW-1:0] eff_ptr, eff_ptr_inc, wr_ptr_next, commit_ptr_next, len_din, len_dout;
    logic          s_fire, restart, data_word, ovf, first;
    logic          len_push, len_pop, len_full, len_empty;

    // Handshake: a word moves on either side exactly in a cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready, and m_* holds while m_valid & !m_ready.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) s_ready = (wr_state == W_IDLE) ? !len_full : 1'b1;
    end

    assign s_fire      = s_valid && s_ready;
    assign restart     = (wr_state == W_PKT) && s_sop;
    assign data_word   = s_fire && (s_sop || (wr_state == W_PKT));
    // A sop inside a packet rewinds to the last commit point before the word is placed.
    assign eff_ptr     = restart ? commit_ptr : wr_ptr;
    assign eff_ptr_inc = eff_ptr + 1'b1;
    assign ovf         = ((eff_ptr - rd_ptr) == DEPTH);
    assign mem_write   = data_word && !ovf;
    assign mem_waddr   = eff_ptr[AWIDTH-1:0];
    assign mem_wdata   = s_data;
    assign len_push    = mem_write && s_eop;
    assign len_din     = eff_ptr_inc - commit_ptr;

    always_comb begin
        wr_next         = wr_state;
        wr_ptr_next     = wr_ptr;
        commit_ptr_next = commit_ptr;
        if (s_fire) begin
            if (data_word) begin
                if (ovf) begin
                    wr_ptr_next = commit_ptr;
                    wr_next     = s_eop ? W_IDLE : W_DROP;
                end else if (s_eop) begin
                    wr_ptr_next     = eff_ptr_inc;
                    commit_ptr_next = eff_ptr_inc;
                    wr_next         = W_IDLE;
                end else begin
                    wr_ptr_next = eff_ptr_inc;
                    wr_next     = W_PKT;
                end
            end else if ((wr_state == W_DROP) && s_eop) begin
                wr_next = W_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state   <= W_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            wr_state   <= wr_next;
            wr_ptr     <= wr_ptr_next;
            commit_ptr <= commit_ptr_next;
        end
    end

    pkt_len_fifo #(
        .DEPTH (LEN_DEPTH),
        .WIDTH (PW)
    ) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (len_push),
        .din   (len_din),
        .pop   (len_pop),
        .dout  (len_dout),
        .full  (len_full),
        .empty (len_empty)
    );

    assign m_valid   = (rd_state == R_PKT);
    assign m_sop     = m_valid && first;
    assign m_eop     = m_valid && (remaining == PW'(1));
    assign m_data    = mem_rdata;
    assign mem_raddr = rd_ptr[AWIDTH-1:0];
    assign len_pop   = m_valid && m_ready && m_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            first     <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (!len_empty) begin
                    remaining <= len_dout;
                    first     <= 1'b1;
                    rd_state  <= R_PKT;
                end
                default: if (m_ready) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    first     <= 1'b0;
                    if (m_eop) rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

`ifdef TX_FIFO_STATS_EN
    logic [15:0]   drop_q;
    logic [CW-1:0] pkt_q;
    logic [1:0]    drop_inc;
    logic [16:0]   drop_sum;

    // A restart that itself overflows loses two packets in one cycle.
    assign drop_inc = {1'b0, s_fire && restart} + {1'b0, data_word && ovf};
    assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            pkt_q  <= '0;
        end else begin
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (len_push && !len_pop)      pkt_q <= pkt_q + 1'b1;
            else if (len_pop && !len_push) pkt_q <= pkt_q - 1'b1;
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_tx_pkt_fifo_ctrl.sv
// Directed bench for tx_pkt_fifo_ctrl (AWIDTH=4, LEN_DEPTH=16) with a memory model and beat scoreboard.
module tb_tx_pkt_fifo_ctrl;
    import tx_fifo_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LD = 16;
    localparam int CW = $clog2(LD + 1);
`ifdef TX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid, m_sop, m_eop;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write;
    logic [CW-1:0] pkt_cnt;
    logic [15:0]   drop_cnt;
    wr_state_e     dbg_wr_state;
    rd_state_e     dbg_rd_state;

    logic [DW-1:0] mem_model [2**AW];
    logic [33:0]   exp_q[$];
    logic [33:0]   held;
    logic          hold_pend = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            exp_drop = 0;

    tx_pkt_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LEN_DEPTH(LD)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_data(m_data), .m_ready(m_ready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
    );

    // Clock and memory model
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_write) mem_model[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem_model[mem_raddr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each transfer, hold check while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend && m_valid) chk("m_hold", {m_sop, m_eop, m_data}, held);
            if (m_valid && m_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("m_beat", {m_sop, m_eop, m_data}, exp_q.pop_front());
            end
            hold_pend = m_valid && !m_ready;
            held      = {m_sop, m_eop, m_data};
        end else begin
            hold_pend = 1'b0;
        end
    end

    // Drives one word from just after a rising edge; waddr < 0 means no memory write expected.
    task automatic send(input logic sop, input logic eop, input logic [DW-1:0] data,
                        input int waddr, input bit deliver);
        bit acc = 1'b0;
        s_valid = 1'b1; s_sop = sop; s_eop = eop; s_data = data;
        if (deliver) exp_q.push_back({sop, eop, data});
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                if (waddr >= 0) begin
                    chk("mem_write", mem_write, 1);
                    chk("mem_waddr", mem_waddr, waddr);
                end else begin
                    chk("mem_write_off", mem_write, 0);
                end
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", acc, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int exp_pkt);
        chk({tag, "_pkt_cnt"}, pkt_cnt, STATS ? exp_pkt : 0);
        chk({tag, "_drop_cnt"}, drop_cnt, STATS ? exp_drop : 0);
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_m_sop_eop", {m_sop, m_eop}, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        exp_drop = 0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        apply_reset();
        @(negedge clk);
        chk("idle_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // Four-word packet at addresses 0..3, output two cycles after eop
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, 32'hA000_0000 + i, i, 1);
        @(negedge clk);
        chk("a_lat_t1", m_valid, 0);
        chk_cnts("a_commit", 1);
        @(negedge clk);
        chk("a_lat_t2", m_valid, 1);
        wait_drain();

        // Single-word packet
        send(1, 1, 32'hB0B0_0001, 4, 1);
        @(negedge clk);
        chk_cnts("b_commit", 1);
        @(negedge clk);
        chk("b_valid", m_valid, 1);
        @(negedge clk);
        chk_cnts("b_popped", 0);
        wait_drain();

        // Oversize packet: 16 words stored then overflow; next packet from address 0
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            send(i == 0, i == 19, 32'hC000_0000 + i, (i < 16) ? i : -1, 0);
            if (i == 16) chk("ovf_state", dbg_wr_state, W_DROP);
        end
        exp_drop = 1;
        chk_cnts("ovf", 0);
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, 32'hC100_0000 + i, i, 1);
        wait_drain();

        // sop after two words restarts at the original start address
        send(1, 0, 32'hD000_0000, 3, 0);
        send(0, 0, 32'hD000_0001, 4, 0);
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, 32'hE000_0000 + i, 3 + i, 1);
        exp_drop = 2;
        chk_cnts("restart", 1);
        wait_drain();

        // Length FIFO fill with output stalled, then drain in order
        m_ready = 1'b0;
        for (int i = 0; i < LD; i++) send(1, 1, 32'hF000_0000 + i, (6 + i) % 16, 1);
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_data = 32'hF000_00FF;
        exp_q.push_back({1'b1, 1'b1, 32'hF000_00FF});
        @(negedge clk);
        chk("full_stall", s_ready, 0);
        chk_cnts("full", LD);
        @(posedge clk); #1 m_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (s_ready) begin
                seen = 1'b1;
                chk("full_resume_waddr", {mem_write, mem_waddr}, {1'b1, 4'd6});
            end
            @(posedge clk); #1;
        end
        chk("full_resume", seen, 1);
        s_valid = 1'b0;
        wait_drain();
        chk_cnts("full_drained", 0);

        // Reset in the middle of reading a packet
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, 32'h1F00_0000 + i, 7 + i, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        chk("mid_valid", seen, 1);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_sop_eop", {m_sop, m_eop}, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        exp_q.delete();
        exp_drop = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, 32'h2000_0000 + i, i, 1);
        wait_drain();
        chk_cnts("final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
